pipe_stage_buffer: RTL and testbench

Parametrised elastic pipeline stage register: the generalised replacement for the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the MIPS pipeline. It carries an arbitrary-width data word and control bundle between two stages. It adds a valid/ready handshake, a one-entry skid buffer so stalls never drop work, a synchronous flush that inserts a bubble, and a saturating stall-cycle counter for performance debug.

---
 rtl/pipe_stage_buffer.sv | 100 ++++++++++
 tb/tb_pipe_stage_buffer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buffer.sv
// pipe_stage_buffer
//   Elastic pipeline stage register with a one-entry skid buffer.
//   Carries a data word plus a control bundle between two pipeline stages
//   under a valid/ready handshake. A flush squashes everything held. A
//   saturating counter records the cycles the output was stalled.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   upstream handshake (in_ready = skid empty)
//   in_data, in_ctrl    upstream payload and control bundle
//   flush               invalidate all held entries at the next edge
//   out_valid/out_ready downstream handshake
//   out_data, out_ctrl  head entry (NOP_DATA / 0 while no entry is valid)
//   occupancy           number of entries held (0..2)
//   stall_count         cycles with out_valid && !out_ready, saturating
module pipe_stage_buffer #(
  parameter int                DATA_W   = 32,
  parameter int                CTRL_W   = 20,
  parameter logic [DATA_W-1:0] NOP_DATA = {DATA_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t           main_q, skid_q;
  logic             main_v, skid_v;
  logic [CNT_W-1:0] stall_q;
  entry_t           in_ent;
  logic             accept, drain;

  assign in_ent = '{data: in_data, ctrl: in_ctrl};

  // in_ready comes only from registered state, so no out_ready->in_ready path.
  assign in_ready = !skid_v;
  assign accept   = in_valid && in_ready;
  assign drain    = main_v && out_ready;

  // Payload registers: no reset needed, the valid flags gate every use.
  // Invariant: skid only holds an entry while main does, so an empty main
  // implies an empty skid and the main-empty branch never touches skid.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (!main_v) begin
      if (accept) begin
        main_q <= in_ent;
        main_v <= 1'b1;
      end
    end else if (drain) begin
      if (skid_v) begin
        // accept cannot happen here: in_ready is low while skid is full
        main_q <= skid_q;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_q <= in_ent;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      skid_q <= in_ent;
      skid_v <= 1'b1;
    end
  end

  // Stall counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)
      stall_q <= '0;
    else if (main_v && !out_ready && (stall_q != {CNT_W{1'b1}}))
      stall_q <= stall_q + 1'b1;
  end

  assign out_valid   = main_v;
  assign out_data    = main_v ? main_q.data : NOP_DATA;
  assign out_ctrl    = main_v ? main_q.ctrl : '0;
  assign occupancy   = {1'b0, main_v} + {1'b0, skid_v};
  assign stall_count = stall_q;

endmodule

// File: tb/tb_pipe_stage_buffer.sv
module tb_pipe_stage_buffer;
  localparam int          DW   = 32;
  localparam int          CW   = 20;
  localparam int          CNTW = 4;
  localparam logic [31:0] NOP  = 32'hDEAD_BEEF;
  localparam int          SMAX = 15;

  logic          clk = 1'b0;
  logic          reset, in_valid, flush, out_ready;
  logic          in_ready, out_valid;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occupancy;
  logic [CNTW-1:0] stall_count;

  pipe_stage_buffer #(.DATA_W(DW), .CTRL_W(CW), .NOP_DATA(NOP), .CNT_W(CNTW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference: FIFO of held entries (capacity 2) plus a saturating stall tally.
  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;
  ent_t q[$];
  int   m_stall;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one clock edge's worth of rules to the reference.
  task automatic model_update();
    int   sz;
    ent_t e;
    if (reset) begin
      q.delete();
      m_stall = 0;
    end else begin
      sz = q.size();
      if (sz > 0 && !out_ready && m_stall < SMAX) m_stall++;
      if (sz > 0 && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && sz < 2) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
    end
  endtask

  task automatic compare();
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    ed = (q.size() > 0) ? q[0].d : NOP;
    ec = (q.size() > 0) ? q[0].c : '0;
    chk("out_valid",   64'(out_valid),   64'(q.size() > 0));
    chk("out_data",    64'(out_data),    64'(ed));
    chk("out_ctrl",    64'(out_ctrl),    64'(ec));
    chk("in_ready",    64'(in_ready),    64'(q.size() < 2));
    chk("occupancy",   64'(occupancy),   64'(q.size()));
    chk("stall_count", 64'(stall_count), 64'(m_stall));
  endtask

  // Inputs change at the negedge; DUT and model both see them at the next posedge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic offer(input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = c;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0; m_stall = 0;
    tick(); tick();
    // reset state pinned by literals
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  64'(out_data),  64'hDEAD_BEEF);
    chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall",     64'(stall_count), 64'd0);
    reset = 1'b0;

    // streaming at full rate: each word visible right after its accept edge
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      offer(32'(32'h11 * (i + 1)), 20'(i + 1));
      tick();
      chk("stream_data", 64'(out_data), 64'(32'h11 * (i + 1)));
      chk("stream_occ",  64'(occupancy), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_empty", 64'(out_valid), 64'd0);
    chk("stream_stall", 64'(stall_count), 64'd0);

    // backpressure: skid fills, in_ready drops, nothing lost
    out_ready = 1'b0;
    offer(32'hA0, 20'h1); tick();
    offer(32'hA1, 20'h2); tick();
    offer(32'hA2, 20'h3); tick(); tick();
    chk("bp_occ",      64'(occupancy), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_stall",    64'(stall_count), 64'd3);
    out_ready = 1'b1;
    tick();
    chk("bp_second", 64'(out_data), 64'hA1);
    tick();
    chk("bp_third",  64'(out_data), 64'hA2);
    offer(32'hA3, 20'h4); tick();
    chk("bp_fourth", 64'(out_data), 64'hA3);
    in_valid = 1'b0; tick();

    // saturation of the stall counter
    out_ready = 1'b0;
    offer(32'hB0, 20'h5); tick();
    offer(32'hB1, 20'h6); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall", 64'(stall_count), 64'd15);

    // flush at occupancy 2 with a live offer: offer is discarded
    offer(32'h44, 20'h7); flush = 1'b1; tick();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_out_data",  64'(out_data),  64'hDEAD_BEEF);
    chk("fl_out_ctrl",  64'(out_ctrl),  64'd0);
    chk("fl_occ",       64'(occupancy), 64'd0);
    chk("fl_in_ready",  64'(in_ready),  64'd1);
    chk("fl_stall",     64'(stall_count), 64'd15);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("fl_no_44", 64'(out_valid), 64'd0);

    // reset beats flush and handshakes
    out_ready = 1'b0;
    offer(32'hC0, 20'h8); tick();
    offer(32'hC1, 20'h9); tick();
    chk("pre_rst_occ", 64'(occupancy), 64'd2);
    reset = 1'b1; flush = 1'b1; offer(32'hC2, 20'hA); tick();
    chk("rst2_out_valid", 64'(out_valid), 64'd0);
    chk("rst2_in_ready",  64'(in_ready),  64'd1);
    chk("rst2_occ",       64'(occupancy), 64'd0);
    chk("rst2_stall",     64'(stall_count), 64'd0);
    reset = 1'b0; flush = 1'b0;

    // randomized traffic against the reference
    for (int i = 0; i < 12000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = $urandom;
      in_ctrl   = 20'($urandom);
      out_ready = ((i / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                        : ($urandom_range(0, 3) == 0);
      flush     = ($urandom_range(0, 63) == 0);
      reset     = ($urandom_range(0, 999) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
